// File: rtl/ascon_perm_sequencer.sv
// Round sequencer for an external single-round Ascon permutation datapath.
// Holds the 320-bit state and steps it through p^a / p^b one round per cycle.
module ascon_perm_sequencer #(
    parameter int MAX_ROUNDS = 12,
    parameter int RND_W      = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [RND_W-1:0] req_rounds_i,
    input  logic [319:0]     req_state_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [319:0]     rsp_state_o,
    output logic [319:0]     rnd_state_o,
    output logic [RND_W-1:0] rnd_idx_o,
    output logic [7:0]       rnd_const_o,
    output logic             rnd_en_o,
    input  logic [319:0]     rnd_state_i,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    localparam logic [RND_W-1:0] MAX_R = RND_W'(MAX_ROUNDS);

    fsm_e             fsm_q, fsm_d;
    logic [319:0]     state_q, state_d;
    logic [RND_W-1:0] cnt_q, cnt_d;
    logic [RND_W-1:0] idx_q, idx_d;
    logic [RND_W-1:0] nr_eff;
    logic             rnd_en, rsp_valid;

    // Ascon round-constant table; unused indices return 0 to stay X-free.
    function automatic logic [7:0] round_const(input logic [RND_W-1:0] idx);
        case (int'(idx))
            0:       round_const = 8'hF0;
            1:       round_const = 8'hE1;
            2:       round_const = 8'hD2;
            3:       round_const = 8'hC3;
            4:       round_const = 8'hB4;
            5:       round_const = 8'hA5;
            6:       round_const = 8'h96;
            7:       round_const = 8'h87;
            8:       round_const = 8'h78;
            9:       round_const = 8'h69;
            10:      round_const = 8'h5A;
            11:      round_const = 8'h4B;
            default: round_const = 8'h00;
        endcase
    endfunction

    always_comb begin
        nr_eff = (req_rounds_i > MAX_R) ? MAX_R : req_rounds_i;
    end

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rnd_en    = 1'b0;
        rsp_valid = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = req_state_i;
                    if (nr_eff == '0) begin
                        fsm_d = DONE;
                    end else begin
                        cnt_d = nr_eff;
                        idx_d = MAX_R - nr_eff;
                        fsm_d = RUN;
                    end
                end
            end
            RUN: begin
                rnd_en  = 1'b1;
                state_d = rnd_state_i;
                idx_d   = idx_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == RND_W'(1)) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready_i) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Handshake and status outputs are forced low while reset is held.
    assign req_ready_o = (fsm_q == IDLE) && rst_ni;
    assign rsp_valid_o = rsp_valid && rst_ni;
    assign rnd_en_o    = rnd_en && rst_ni;
    assign busy_o      = (fsm_q != IDLE) && rst_ni;
    assign rsp_state_o = state_q;
    assign rnd_state_o = state_q;
    assign rnd_idx_o   = idx_q;
    assign rnd_const_o = round_const(idx_q);

endmodule
